// File: rtl/systolic_seq_ctrl.sv
// Job sequencer for an N x N output-stationary systolic MAC array: clears the array, feeds skewed
// A/B operands from two memories, waits for the pipeline to flush, then streams C row-major.
module systolic_seq_ctrl #(
  parameter int unsigned N     = 4,
  parameter int unsigned DW    = 16,
  parameter int unsigned K_MAX = 16,
  parameter int unsigned AW    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [4:0]        k_len,
  output logic              busy,
  output logic              done,
  output logic              a_rd_en,
  output logic [AW-1:0]     a_rd_addr,
  input  logic [N*DW-1:0]   a_rd_data,
  output logic              b_rd_en,
  output logic [AW-1:0]     b_rd_addr,
  input  logic [N*DW-1:0]   b_rd_data,
  output logic [N*DW-1:0]   a_edge,
  output logic [N*DW-1:0]   b_edge,
  output logic              pe_clr,
  input  logic [N*N*DW-1:0] c_in,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DW-1:0]     res_data,
  output logic [3:0]        res_idx
);

  localparam int unsigned NN       = N * N;
  localparam int unsigned FlushLen = 2 * N - 1;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StFeed,
    StFlush,
    StDrain,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [4:0]          k_q;
  logic [4:0]          cnt_q, cnt_d;
  logic [3:0]          idx_q, idx_d;
  logic                dv_q;
  logic                snap_pend_q;
  logic [N*N*DW-1:0]   cbuf_q;
  logic [N*N*DW-1:0]   c_src;
  logic [N*DW-1:0]     a_gated, b_gated;

  // ---------------------------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StClear;
      end
      StClear: begin
        cnt_d   = '0;
        state_d = (k_q != 5'd0) ? StFeed : StFlush;
      end
      StFeed: begin
        if (cnt_q == k_q - 5'd1) begin
          cnt_d   = '0;
          state_d = StFlush;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      StFlush: begin
        if (cnt_q == 5'(FlushLen - 1)) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = StDrain;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      StDrain: begin
        if (res_ready) begin
          if (idx_q == 4'(NN - 1)) begin
            idx_d   = '0;
            state_d = StDone;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Out-of-range lengths are clamped so the feed never runs past the operand memories.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_q <= '0;
    end else if (state_q == StIdle && start) begin
      k_q <= (32'(k_len) > K_MAX) ? 5'(K_MAX) : k_len;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Operand skew: row/column i is delayed by i registers so A[i][k] and B[k][j] meet in PE(i,j)
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      dv_q <= 1'b0;
    end else begin
      dv_q <= a_rd_en;
    end
  end

  assign a_gated = dv_q ? a_rd_data : '0;
  assign b_gated = dv_q ? b_rd_data : '0;

  assign a_edge[0 +: DW] = a_gated[0 +: DW];
  assign b_edge[0 +: DW] = b_gated[0 +: DW];

  for (genvar i = 1; i < N; i++) begin : g_skew
    logic [DW-1:0] a_pipe_q [i];
    logic [DW-1:0] b_pipe_q [i];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int d = 0; d < i; d++) begin
          a_pipe_q[d] <= '0;
          b_pipe_q[d] <= '0;
        end
      end else begin
        a_pipe_q[0] <= a_gated[i*DW +: DW];
        b_pipe_q[0] <= b_gated[i*DW +: DW];
        for (int d = 1; d < i; d++) begin
          a_pipe_q[d] <= a_pipe_q[d-1];
          b_pipe_q[d] <= b_pipe_q[d-1];
        end
      end
    end

    assign a_edge[i*DW +: DW] = a_pipe_q[i-1];
    assign b_edge[i*DW +: DW] = b_pipe_q[i-1];
  end

  // ---------------------------------------------------------------------------------------------
  // Result snapshot. The last product lands in the array on the same edge that enters DRAIN, so
  // the buffer is loaded at the end of the first DRAIN cycle and that cycle shows c_in directly;
  // both paths present the same value, keeping the output stable under backpressure.
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_pend_q <= 1'b0;
      cbuf_q      <= '0;
    end else if (state_q == StFlush && state_d == StDrain) begin
      snap_pend_q <= 1'b1;
    end else if (state_q == StDrain && snap_pend_q) begin
      snap_pend_q <= 1'b0;
      cbuf_q      <= c_in;
    end
  end

  assign c_src = snap_pend_q ? c_in : cbuf_q;

  // ---------------------------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    busy      = (state_q != StIdle);
    done      = (state_q == StDone);
    a_rd_en   = (state_q == StFeed);
    b_rd_en   = (state_q == StFeed);
    a_rd_addr = a_rd_en ? cnt_q[AW-1:0] : '0;
    b_rd_addr = b_rd_en ? cnt_q[AW-1:0] : '0;
    pe_clr    = rst || (state_q == StClear);
    res_valid = (state_q == StDrain);
    res_idx   = res_valid ? idx_q : '0;
    res_data  = res_valid ? c_src[idx_q*DW +: DW] : '0;
  end

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Directed bench for systolic_seq_ctrl with a behavioural Q8.8 output-stationary array and
// one-cycle-latency operand memories.
module tb_systolic_seq_ctrl;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int AW = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [4:0]        k_len;
  logic              busy, done;
  logic              a_rd_en, b_rd_en;
  logic [AW-1:0]     a_rd_addr, b_rd_addr;
  logic [N*DW-1:0]   a_rd_data, b_rd_data;
  logic [N*DW-1:0]   a_edge, b_edge;
  logic              pe_clr;
  logic [N*N*DW-1:0] c_in;
  logic              res_valid, res_ready;
  logic [DW-1:0]     res_data;
  logic [3:0]        res_idx;

  systolic_seq_ctrl #(.N(N), .DW(DW), .K_MAX(16), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .k_len     (k_len),
    .busy      (busy),
    .done      (done),
    .a_rd_en   (a_rd_en),
    .a_rd_addr (a_rd_addr),
    .a_rd_data (a_rd_data),
    .b_rd_en   (b_rd_en),
    .b_rd_addr (b_rd_addr),
    .b_rd_data (b_rd_data),
    .a_edge    (a_edge),
    .b_edge    (b_edge),
    .pe_clr    (pe_clr),
    .c_in      (c_in),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_idx   (res_idx)
  );

  always #5 clk = ~clk;

  // Operand memories
  logic [N*DW-1:0] amem [16];
  logic [N*DW-1:0] bmem [16];

  always @(posedge clk) begin
    if (a_rd_en) a_rd_data <= amem[a_rd_addr];
    if (b_rd_en) b_rd_data <= bmem[b_rd_addr];
  end

  // Behavioural array: A flows east, B flows south, each PE accumulates Q8.8 products.
  logic [DW-1:0] acc [N][N];
  logic [DW-1:0] ah  [N][N];
  logic [DW-1:0] bv  [N][N];
  logic [DW-1:0] a_in [N][N];
  logic [DW-1:0] b_in [N][N];

  function automatic logic [DW-1:0] qmul(input logic signed [DW-1:0] a,
                                         input logic signed [DW-1:0] b);
    logic signed [2*DW-1:0] p;
    p = a * b;
    return p[DW+7:8];
  endfunction

  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_in[i][0] = a_edge[i*DW +: DW];
      for (int j = 1; j < N; j++) a_in[i][j] = ah[i][j-1];
    end
    for (int j = 0; j < N; j++) begin
      b_in[0][j] = b_edge[j*DW +: DW];
      for (int i = 1; i < N; i++) b_in[i][j] = bv[i-1][j];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (pe_clr) begin
          acc[i][j] <= '0;
          ah[i][j]  <= '0;
          bv[i][j]  <= '0;
        end else begin
          acc[i][j] <= acc[i][j] + qmul(a_in[i][j], b_in[i][j]);
          ah[i][j]  <= a_in[i][j];
          bv[i][j]  <= b_in[i][j];
        end
      end
    end
  end

  always_comb begin
    c_in = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) c_in[(i*N+j)*DW +: DW] = acc[i][j];
  end

  // Counters and per-job observations
  int n_cmp = 0;
  int n_bad = 0;

  int            lat, n_rd, addr_bad, n_clr, n_done, res_n, last_acc, done_cyc, hold_bad;
  logic          busy_at_done, busy_after1, busy_after2;
  bit            finished;
  int            log_idx  [32];
  logic [DW-1:0] log_data [32];

  function automatic logic [DW-1:0] exp_identity(input int n);
    return (n == 0 || n == 5 || n == 10 || n == 15) ? 16'h0100 : 16'h0000;
  endfunction

  task automatic load_identity();
    for (int k = 0; k < 16; k++) begin
      amem[k] = '0;
      bmem[k] = '0;
    end
    for (int k = 0; k < N; k++) begin
      amem[k][k*DW +: DW] = 16'h0100;
      bmem[k][k*DW +: DW] = 16'h0100;
    end
  endtask

  task automatic load_const(input logic [DW-1:0] av, input logic [DW-1:0] bval);
    for (int k = 0; k < 16; k++) begin
      amem[k] = {N{av}};
      bmem[k] = {N{bval}};
    end
  endtask

  // rmode 0: ready always high; rmode 1: ready pattern 1,0,0 repeating.
  // glitch: pulse start once during FLUSH and again during DONE.
  task automatic run_job(input int k, input int rmode, input bit glitch);
    int   cyc;
    bit   hold_chk;
    logic [3:0]    h_idx;
    logic [DW-1:0] h_data;
    lat = -1; n_rd = 0; addr_bad = 0; n_clr = 0; n_done = 0; res_n = 0;
    last_acc = -1; done_cyc = -1; hold_bad = 0; finished = 0;
    busy_at_done = 1'bx; busy_after1 = 1'bx; busy_after2 = 1'bx;
    hold_chk = 0; h_idx = '0; h_data = '0;
    k_len = 5'(k);
    start = 1'b1;
    res_ready = 1'b0;
    @(posedge clk); #1;
    cyc = 1;
    for (int g = 0; g < 300; g++) begin
      res_ready = (rmode == 0) ? 1'b1 : ((cyc % 3) == 0);
      start     = glitch && (cyc == k + 5);
      if (a_rd_en) begin
        if (int'(a_rd_addr) != n_rd || !b_rd_en || b_rd_addr != a_rd_addr) addr_bad++;
        n_rd++;
      end
      if (b_rd_en && !a_rd_en) addr_bad++;
      if (pe_clr) n_clr++;
      if (res_valid && lat < 0) lat = cyc;
      if (hold_chk && (res_idx !== h_idx || res_data !== h_data)) hold_bad++;
      hold_chk = res_valid && !res_ready;
      h_idx = res_idx;
      h_data = res_data;
      if (res_valid && res_ready && res_n < 32) begin
        log_idx[res_n]  = int'(res_idx);
        log_data[res_n] = res_data;
        res_n++;
        last_acc = cyc;
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
        busy_at_done = busy;
        if (glitch) start = 1'b1;
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) busy_after1 = busy;
      if (done_cyc >= 0 && cyc == done_cyc + 2) begin
        busy_after2 = busy;
        finished = 1;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    res_ready = 1'b0;
    n_cmp++;
    if (!finished) begin
      n_bad++;
      $display("FAIL job_timeout: k=%0d results=%0d done_seen=%0d, required done within budget",
               k, res_n, n_done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; k_len = '0; res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, done, a_rd_en, b_rd_en, res_valid} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: busy/done/a_en/b_en/valid=%b required 00000",
               {busy, done, a_rd_en, b_rd_en, res_valid});
    end
    n_cmp++;
    if (res_data !== 16'h0 || res_idx !== 4'h0) begin
      n_bad++;
      $display("FAIL reset_res: data=%h idx=%h required 0/0", res_data, res_idx);
    end
    n_cmp++;
    if (a_edge !== '0 || b_edge !== '0) begin
      n_bad++;
      $display("FAIL reset_edges: a=%h b=%h required 0", a_edge, b_edge);
    end
    n_cmp++;
    if (pe_clr !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_pe_clr: got %b required 1", pe_clr);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (pe_clr !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_after_reset: pe_clr=%b busy=%b required 0/0", pe_clr, busy);
    end
  endtask

  task automatic test_identity();
    load_identity();
    run_job(4, 0, 0);
    n_cmp++;
    if (res_n != 16) begin
      n_bad++;
      $display("FAIL ident_count: got %0d results required 16", res_n);
    end
    for (int n = 0; n < 16 && n < res_n; n++) begin
      n_cmp++;
      if (log_idx[n] != n || log_data[n] !== exp_identity(n)) begin
        n_bad++;
        $display("FAIL ident_res[%0d]: idx=%0d data=%h required idx=%0d data=%h",
                 n, log_idx[n], log_data[n], n, exp_identity(n));
      end
    end
    n_cmp++;
    if (done_cyc != last_acc + 1 || n_done != 1) begin
      n_bad++;
      $display("FAIL ident_done: done at %0d (x%0d) last handshake %0d, required +1 once",
               done_cyc, n_done, last_acc);
    end
    n_cmp++;
    if (n_rd != 4 || addr_bad != 0 || n_clr != 1) begin
      n_bad++;
      $display("FAIL ident_reads: reads=%0d addr_err=%0d clr=%0d required 4/0/1",
               n_rd, addr_bad, n_clr);
    end
    n_cmp++;
    if (busy_at_done !== 1'b1 || busy_after1 !== 1'b0) begin
      n_bad++;
      $display("FAIL ident_busy: at done=%b after=%b required 1/0", busy_at_done, busy_after1);
    end
  endtask

  task automatic test_const_latency();
    load_const(16'h0200, 16'h0180);
    run_job(4, 0, 0);
    n_cmp++;
    if (lat != 13) begin
      n_bad++;
      $display("FAIL const_latency: first valid at cycle %0d required 13", lat);
    end
    n_cmp++;
    if (res_n != 16) begin
      n_bad++;
      $display("FAIL const_count: got %0d required 16", res_n);
    end
    for (int n = 0; n < 16 && n < res_n; n++) begin
      n_cmp++;
      if (log_idx[n] != n || log_data[n] !== 16'h0C00) begin
        n_bad++;
        $display("FAIL const_res[%0d]: idx=%0d data=%h required idx=%0d data=0c00",
                 n, log_idx[n], log_data[n], n);
      end
    end
  endtask

  task automatic test_backpressure();
    load_const(16'h0200, 16'h0180);
    run_job(4, 1, 0);
    n_cmp++;
    if (hold_bad != 0) begin
      n_bad++;
      $display("FAIL bp_hold: %0d changes while stalled, required 0", hold_bad);
    end
    n_cmp++;
    if (res_n != 16 || n_done != 1) begin
      n_bad++;
      $display("FAIL bp_count: results=%0d done=%0d required 16/1", res_n, n_done);
    end
    for (int n = 0; n < 16 && n < res_n; n++) begin
      n_cmp++;
      if (log_idx[n] != n || log_data[n] !== 16'h0C00) begin
        n_bad++;
        $display("FAIL bp_res[%0d]: idx=%0d data=%h required idx=%0d data=0c00",
                 n, log_idx[n], log_data[n], n);
      end
    end
  endtask

  task automatic test_k_zero();
    load_const(16'h0200, 16'h0180);
    run_job(0, 0, 0);
    n_cmp++;
    if (n_rd != 0 || addr_bad != 0 || n_clr != 1) begin
      n_bad++;
      $display("FAIL kzero_ctrl: reads=%0d addr_err=%0d clr=%0d required 0/0/1",
               n_rd, addr_bad, n_clr);
    end
    n_cmp++;
    if (lat != 9 || res_n != 16 || n_done != 1) begin
      n_bad++;
      $display("FAIL kzero_flow: lat=%0d results=%0d done=%0d required 9/16/1",
               lat, res_n, n_done);
    end
    for (int n = 0; n < 16 && n < res_n; n++) begin
      n_cmp++;
      if (log_idx[n] != n || log_data[n] !== 16'h0000) begin
        n_bad++;
        $display("FAIL kzero_res[%0d]: idx=%0d data=%h required idx=%0d data=0000",
                 n, log_idx[n], log_data[n], n);
      end
    end
  endtask

  task automatic test_reset_mid_feed();
    load_identity();
    k_len = 5'd4;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int g = 0; g < 20 && !(a_rd_en && a_rd_addr == 4'd2); g++) begin
      @(posedge clk); #1;
    end
    n_cmp++;
    if (!(a_rd_en && a_rd_addr == 4'd2)) begin
      n_bad++;
      $display("FAIL midfeed_reach: a_en=%b addr=%0d required 1/2", a_rd_en, a_rd_addr);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (pe_clr !== 1'b1) begin
      n_bad++;
      $display("FAIL midfeed_clr_now: pe_clr=%b required 1", pe_clr);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || done !== 1'b0 || a_rd_en !== 1'b0) begin
      n_bad++;
      $display("FAIL midfeed_ctrl: busy=%b valid=%b done=%b a_en=%b required 0000",
               busy, res_valid, done, a_rd_en);
    end
    n_cmp++;
    if (a_edge !== '0 || b_edge !== '0 || pe_clr !== 1'b1) begin
      n_bad++;
      $display("FAIL midfeed_edges: a=%h b=%h pe_clr=%b required 0/0/1", a_edge, b_edge, pe_clr);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    run_job(4, 0, 0);
    n_cmp++;
    if (res_n != 16 || n_done != 1) begin
      n_bad++;
      $display("FAIL midfeed_rerun_count: results=%0d done=%0d required 16/1", res_n, n_done);
    end
    for (int n = 0; n < 16 && n < res_n; n++) begin
      n_cmp++;
      if (log_idx[n] != n || log_data[n] !== exp_identity(n)) begin
        n_bad++;
        $display("FAIL midfeed_res[%0d]: idx=%0d data=%h required idx=%0d data=%h",
                 n, log_idx[n], log_data[n], n, exp_identity(n));
      end
    end
  endtask

  task automatic test_start_ignored();
    load_identity();
    run_job(4, 0, 1);
    n_cmp++;
    if (n_done != 1 || res_n != 16 || n_clr != 1) begin
      n_bad++;
      $display("FAIL ignstart_count: done=%0d results=%0d clr=%0d required 1/16/1",
               n_done, res_n, n_clr);
    end
    n_cmp++;
    if (busy_at_done !== 1'b1 || busy_after1 !== 1'b0 || busy_after2 !== 1'b0) begin
      n_bad++;
      $display("FAIL ignstart_busy: done=%b +1=%b +2=%b required 1/0/0",
               busy_at_done, busy_after1, busy_after2);
    end
    for (int n = 0; n < 16 && n < res_n; n++) begin
      n_cmp++;
      if (log_idx[n] != n || log_data[n] !== exp_identity(n)) begin
        n_bad++;
        $display("FAIL ignstart_res[%0d]: idx=%0d data=%h required idx=%0d data=%h",
                 n, log_idx[n], log_data[n], n, exp_identity(n));
      end
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_const_latency();
    test_backpressure();
    test_k_zero();
    test_reset_mid_feed();
    test_start_ignored();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
